decade_chain_ctrl: RTL

Controller and sequencer for a cascaded chain of decade (BCD 0-9) counters in the lab counter designs.
- Generates the count-enable tick from the system clock with a prescaler.
- Runs a start/pause/clear/load state machine.
- Ripples carries and borrows across the digits, detects a programmable terminal count and flags completion.
- Drives the display/scan logic downstream via the packed BCD count.

---
 rtl/decade_pkg.sv | 26 ++
 rtl/bcd_digit.sv | 25 ++
 rtl/decade_chain_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/decade_pkg.sv
// Shared types and BCD helpers for the cascaded decade counter chain.
package decade_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One BCD step in the requested direction, wrapping 9->0 / 0->9.
  function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] q,
                                                input logic up);
    if (up) return (q >= BCD_MAX) ? BCD_W'(0) : q + BCD_W'(1);
    else    return (q == BCD_W'(0)) ? BCD_MAX : q - BCD_W'(1);
  endfunction

  // Non-decimal preset digits saturate to 9.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single decade digit with clear, preset and carry/borrow out.
module bcd_digit
  import decade_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [BCD_W-1:0] q,
  output logic             co
);

  always_ff @(posedge clk) begin
    if (rst || clr)  q <= '0;
    else if (ld)     q <= bcd_clamp(ld_val);
    else if (en)     q <= bcd_step(q, up_dn);
  end

  // Carry/borrow is combinational so the whole chain ripples in one cycle.
  assign co = en & (up_dn ? (q == BCD_MAX) : (q == BCD_W'(0)));

endmodule

// File: rtl/decade_chain_ctrl.sv
// Sequencer for a chain of decade counters: prescaled tick, run/pause/done
// state machine, terminal-count detect and wrap flag.
module decade_chain_ctrl
  import decade_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  input  logic [BCD_W*DIGITS-1:0] limit,
  input  logic                    up_dn,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    running,
  output logic                    done,
  output logic                    wrap
);

  localparam int unsigned CNT_W = BCD_W * DIGITS;
  localparam int unsigned PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  state_t            state, state_n;
  logic [PS_W-1:0]   ps;
  logic              tick;
  logic [DIGITS:0]   carry;
  logic [CNT_W-1:0]  next_count;
  logic              hit;

  // A step is suppressed whenever a higher-priority command lands this cycle.
  assign tick = (state == RUN) && (ps == PS_LAST) && !clear && !load && !stop;

  always_ff @(posedge clk) begin
    if (rst || clear || load) begin
      ps <= '0;
    end else if (state == RUN && !stop) begin
      ps <= tick ? '0 : ps + PS_W'(1);
    end
  end

  assign carry[0] = tick;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .rst    (rst),
      .clr    (clear),
      .ld     (load),
      .ld_val (load_val[i*BCD_W +: BCD_W]),
      .en     (carry[i]),
      .up_dn  (up_dn),
      .q      (count[i*BCD_W +: BCD_W]),
      .co     (carry[i+1])
    );
  end

  // Value the chain will hold after this cycle's step, for terminal detect.
  always_comb begin
    next_count = count;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry[i]) next_count[i*BCD_W +: BCD_W] = bcd_step(count[i*BCD_W +: BCD_W], up_dn);
    end
  end

  assign hit = tick && (next_count == limit);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (clear || load) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (!stop && start) state_n = RUN;
        RUN:     if (stop) state_n = PAUSE;
                 else if (hit) state_n = DONE;
        PAUSE:   if (!stop && start) state_n = RUN;
        DONE:    if (!stop && start) state_n = RUN;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      running <= (state_n == RUN);
      done    <= (state_n == DONE);
      wrap    <= carry[DIGITS];
    end
  end

endmodule
